// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU fetch/load-store ports, the arbiter and the word-addressed memory.
// MEM_ARB_LOADER_EN adds the boot-loader write port and the cpu_hold stall output.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;

    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_write_enable;
    logic [31:0] mem_data_out;

`ifdef MEM_ARB_LOADER_EN
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic        cpu_hold;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_data_out,
        input  ld_req, ld_addr, ld_wdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        output mem_address, mem_data_in, mem_write_enable, ld_gnt, cpu_hold
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_data_out,
        output ld_req, ld_addr, ld_wdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        input  mem_address, mem_data_in, mem_write_enable, ld_gnt, cpu_hold
    );
`else
    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_data_out,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        output mem_address, mem_data_in, mem_write_enable
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_data_out,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        input  mem_address, mem_data_in, mem_write_enable
    );
`endif
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port memory between instruction fetch and load/store, with starvation guard.
// Optional boot-loader write port with absolute priority is enabled by defining MEM_ARB_LOADER_EN.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RD_IF,
        RD_LS
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic [29:0]      last_addr;
    logic [31:0]      last_wdata;
    logic [31:0]      if_hold;
    logic [31:0]      ls_hold;

    logic        starved;
    logic        ld_win;
    logic        if_win;
    logic        ls_win;
    logic        write_win;
    logic [29:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        unused_addr_bits;

    assign starved          = starve_cnt >= CNT_W'(STARVE_LIMIT);
    assign unused_addr_bits = ^{bus.if_addr[1:0], bus.ls_addr[1:0]};

`ifdef MEM_ARB_LOADER_EN
    logic ld_prev;
    logic unused_ld_bits;

    assign ld_win         = bus.ld_req;
    assign unused_ld_bits = ^bus.ld_addr[1:0];
    assign bus.ld_gnt     = !rst && ld_win;
    // The core stays stalled one extra cycle so the last loader write settles first.
    assign bus.cpu_hold   = !rst && (bus.ld_req || ld_prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_prev <= 1'b0;
        end else begin
            ld_prev <= bus.ld_req;
        end
    end
`else
    assign ld_win = 1'b0;
`endif

    always_comb begin
        if_win    = bus.if_req && !ld_win && (!bus.ls_req || starved);
        ls_win    = bus.ls_req && !ld_win && !if_win;
        write_win = 1'b0;
        sel_addr  = last_addr;
        sel_wdata = last_wdata;
`ifdef MEM_ARB_LOADER_EN
        if (ld_win) begin
            sel_addr  = bus.ld_addr[31:2];
            sel_wdata = bus.ld_wdata;
            write_win = 1'b1;
        end else
`endif
        if (if_win) begin
            sel_addr = bus.if_addr[31:2];
        end else if (ls_win) begin
            sel_addr = bus.ls_addr[31:2];
            if (bus.ls_we) begin
                sel_wdata = bus.ls_wdata;
                write_win = 1'b1;
            end
        end
    end

    // Every output is forced low during reset so an in-flight read never escapes.
    assign bus.if_gnt           = !rst && if_win;
    assign bus.ls_gnt           = !rst && ls_win;
    assign bus.mem_address      = rst ? 32'd0 : {2'b00, sel_addr};
    assign bus.mem_data_in      = rst ? 32'd0 : sel_wdata;
    assign bus.mem_write_enable = !rst && write_win;
    assign bus.if_rvalid        = !rst && (state == RD_IF);
    assign bus.ls_rvalid        = !rst && (state == RD_LS);
    assign bus.if_rdata         = rst ? 32'd0 : ((state == RD_IF) ? bus.mem_data_out : if_hold);
    assign bus.ls_rdata         = rst ? 32'd0 : ((state == RD_LS) ? bus.mem_data_out : ls_hold);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            last_addr  <= '0;
            last_wdata <= '0;
            if_hold    <= '0;
            ls_hold    <= '0;
        end else begin
            last_addr  <= sel_addr;
            last_wdata <= sel_wdata;

            if (state == RD_IF) begin
                if_hold <= bus.mem_data_out;
            end
            if (state == RD_LS) begin
                ls_hold <= bus.mem_data_out;
            end

            if (if_win) begin
                state <= RD_IF;
            end else if (ls_win && !bus.ls_we) begin
                state <= RD_LS;
            end else begin
                state <= IDLE;
            end

            // Loader cycles freeze the counter rather than charging the denial to load/store.
            if (!bus.if_req || if_win) begin
                starve_cnt <= '0;
            end else if (!ld_win && !starved) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the arbitration and memory behaviour.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    function automatic logic [31:0] initWord(input int i);
        return (i == 4) ? 32'h00500093 : (32'hC0DE0000 + 32'(i));
    endfunction

    // Synchronous memory: one-cycle read latency, reloaded with a known image on reset.
    logic [31:0] tb_mem [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= initWord(i);
        end else if (bus.mem_write_enable) begin
            tb_mem[bus.mem_address[7:0]] <= bus.mem_data_in;
        end
        bus.mem_data_out <= tb_mem[bus.mem_address[7:0]];
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    int          m_starve;
    logic        m_pend_if, m_pend_ls, m_ld_prev;
    logic [31:0] m_pend_data, m_if_hold, m_ls_hold, m_last_wdata;
    logic [29:0] m_last_addr;

    // Values seen in the most recent cycle, for the directed scenario checks
    logic        obs_if_gnt, obs_ls_gnt, obs_if_rvalid, obs_ls_rvalid, obs_we;
    logic [31:0] obs_if_rdata, obs_ls_rdata, obs_addr;
    logic        obs_ld_gnt, obs_cpu_hold;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic lsr,
                                 input logic lswe, input logic [31:0] lsa, input logic [31:0] lsd);
        bus.if_req   = ifr;
        bus.if_addr  = ifa;
        bus.ls_req   = lsr;
        bus.ls_we    = lswe;
        bus.ls_addr  = lsa;
        bus.ls_wdata = lsd;
    endtask

    task automatic evalCycle();
        logic        ldr, exp_if, exp_ls, exp_we;
        logic [31:0] lda, ldd, exp_din;
        logic [29:0] exp_addr;
        ldr = 1'b0; lda = '0; ldd = '0;
        obs_ld_gnt = 1'b0; obs_cpu_hold = 1'b0;
`ifdef MEM_ARB_LOADER_EN
        ldr = bus.ld_req; lda = bus.ld_addr; ldd = bus.ld_wdata;
        obs_ld_gnt = bus.ld_gnt; obs_cpu_hold = bus.cpu_hold;
`endif
        obs_if_gnt = bus.if_gnt; obs_ls_gnt = bus.ls_gnt;
        obs_if_rvalid = bus.if_rvalid; obs_ls_rvalid = bus.ls_rvalid;
        obs_if_rdata = bus.if_rdata; obs_ls_rdata = bus.ls_rdata;
        obs_addr = bus.mem_address; obs_we = bus.mem_write_enable;

        if (rst) begin
            checkOutput("rst_if_gnt", bus.if_gnt, 0);
            checkOutput("rst_ls_gnt", bus.ls_gnt, 0);
            checkOutput("rst_if_rvalid", bus.if_rvalid, 0);
            checkOutput("rst_ls_rvalid", bus.ls_rvalid, 0);
            checkOutput("rst_if_rdata", bus.if_rdata, 0);
            checkOutput("rst_ls_rdata", bus.ls_rdata, 0);
            checkOutput("rst_mem_address", bus.mem_address, 0);
            checkOutput("rst_mem_data_in", bus.mem_data_in, 0);
            checkOutput("rst_mem_we", bus.mem_write_enable, 0);
`ifdef MEM_ARB_LOADER_EN
            checkOutput("rst_ld_gnt", bus.ld_gnt, 0);
            checkOutput("rst_cpu_hold", bus.cpu_hold, 0);
`endif
            m_starve = 0; m_pend_if = 0; m_pend_ls = 0; m_ld_prev = 0;
            m_if_hold = '0; m_ls_hold = '0; m_last_addr = '0; m_last_wdata = '0;
            for (int i = 0; i < 256; i++) ref_mem[i] = initWord(i);
            return;
        end

        exp_if = !ldr && bus.if_req && (!bus.ls_req || m_starve >= STARVE_LIMIT);
        exp_ls = !ldr && bus.ls_req && !exp_if;
        checkOutput("if_gnt", bus.if_gnt, exp_if);
        checkOutput("ls_gnt", bus.ls_gnt, exp_ls);
`ifdef MEM_ARB_LOADER_EN
        checkOutput("ld_gnt", bus.ld_gnt, ldr);
        checkOutput("cpu_hold", bus.cpu_hold, ldr || m_ld_prev);
`endif
        m_ld_prev = ldr;

        checkOutput("if_rvalid", bus.if_rvalid, m_pend_if);
        if (m_pend_if) m_if_hold = m_pend_data;
        checkOutput("if_rdata", bus.if_rdata, m_if_hold);
        checkOutput("ls_rvalid", bus.ls_rvalid, m_pend_ls);
        if (m_pend_ls) m_ls_hold = m_pend_data;
        checkOutput("ls_rdata", bus.ls_rdata, m_ls_hold);

        exp_we = 1'b0; exp_addr = m_last_addr; exp_din = m_last_wdata;
        if (ldr) begin
            exp_addr = lda[31:2]; exp_din = ldd; exp_we = 1'b1;
        end else if (exp_if) begin
            exp_addr = bus.if_addr[31:2];
        end else if (exp_ls) begin
            exp_addr = bus.ls_addr[31:2];
            if (bus.ls_we) begin
                exp_din = bus.ls_wdata; exp_we = 1'b1;
            end
        end
        checkOutput("mem_address", bus.mem_address, {2'b00, exp_addr});
        checkOutput("mem_we", bus.mem_write_enable, exp_we);
        checkOutput("mem_data_in", bus.mem_data_in, exp_din);

        m_pend_if   = exp_if;
        m_pend_ls   = exp_ls && !bus.ls_we;
        m_pend_data = ref_mem[exp_addr[7:0]];
        if (exp_we) ref_mem[exp_addr[7:0]] = exp_din;
        m_last_addr  = exp_addr;
        m_last_wdata = exp_din;

        if (!bus.if_req || exp_if) m_starve = 0;
        else if (!ldr && m_starve < STARVE_LIMIT) m_starve++;
    endtask

    task automatic step();
        @(negedge clk);
        evalCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setLoader(input logic req, input logic [31:0] addr, input logic [31:0] data);
`ifdef MEM_ARB_LOADER_EN
        bus.ld_req = req; bus.ld_addr = addr; bus.ld_wdata = data;
`else
        if (req || (addr != 0) || (data != 0)) $display("[TB] loader port not built, request ignored");
`endif
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        setLoader(0, 0, 0);
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;

        // Fetch only
        applyStimulus(1, 32'h10, 0, 0, 0, 0); step();
        checkOutput("t1_gnt", obs_if_gnt, 1);
        checkOutput("t1_addr", obs_addr, 4);
        applyStimulus(0, 0, 0, 0, 0, 0); step();
        checkOutput("t1_rvalid", obs_if_rvalid, 1);
        checkOutput("t1_rdata", obs_if_rdata, 32'h00500093);

        // Store then load of the same word
        applyStimulus(0, 0, 1, 1, 32'h20, 32'hDEADBEEF); step();
        checkOutput("t2_we", obs_we, 1);
        checkOutput("t2_addr", obs_addr, 8);
        applyStimulus(0, 0, 1, 0, 32'h20, 0); step();
        checkOutput("t2_store_no_rvalid", obs_ls_rvalid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0); step();
        checkOutput("t2_rvalid", obs_ls_rvalid, 1);
        checkOutput("t2_rdata", obs_ls_rdata, 32'hDEADBEEF);

        // Sustained contention: fetch breaks through every fifth cycle
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 32'h100 + 32'(i * 4), 1, 0, 32'h200 + 32'(i * 4), 0); step();
            checkOutput($sformatf("t3_if_gnt_%0d", i), obs_if_gnt, (i == 4 || i == 9));
            checkOutput($sformatf("t3_ls_gnt_%0d", i), obs_ls_gnt, !(i == 4 || i == 9));
        end

        // Back-to-back alternating reads
        applyStimulus(1, 32'h0, 0, 0, 0, 0); step();
        applyStimulus(0, 0, 1, 0, 32'h4, 0); step();
        checkOutput("t4_if_rvalid0", obs_if_rvalid, 1);
        checkOutput("t4_if_rdata0", obs_if_rdata, initWord(0));
        applyStimulus(1, 32'h8, 0, 0, 0, 0); step();
        checkOutput("t4_ls_rvalid1", obs_ls_rvalid, 1);
        checkOutput("t4_ls_rdata1", obs_ls_rdata, initWord(1));
        applyStimulus(0, 0, 0, 0, 0, 0); step();
        checkOutput("t4_if_rvalid2", obs_if_rvalid, 1);
        checkOutput("t4_if_rdata2", obs_if_rdata, initWord(2));

        // Reset while a load is in flight
        applyStimulus(0, 0, 1, 0, 32'h24, 0); step();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0); step();
        checkOutput("t5_rst_rvalid", obs_ls_rvalid, 0);
        rst = 1'b0; step();
        checkOutput("t5_post_rvalid", obs_ls_rvalid, 0);
        applyStimulus(1, 32'h10, 0, 0, 0, 0); step();
        checkOutput("t5_gnt", obs_if_gnt, 1);
        applyStimulus(0, 0, 0, 0, 0, 0); step();
        checkOutput("t5_rdata", obs_if_rdata, 32'h00500093);

`ifdef MEM_ARB_LOADER_EN
        // Loader write overrides fetch and stalls the core one cycle past its release
        setLoader(1, 32'h0, 32'h13);
        applyStimulus(1, 32'h0, 0, 0, 0, 0); step();
        checkOutput("t6_ld_gnt", obs_ld_gnt, 1);
        checkOutput("t6_if_gnt", obs_if_gnt, 0);
        checkOutput("t6_hold", obs_cpu_hold, 1);
        setLoader(0, 0, 0); step();
        checkOutput("t6_hold_tail", obs_cpu_hold, 1);
        checkOutput("t6_if_gnt_after", obs_if_gnt, 1);
        applyStimulus(0, 0, 0, 0, 0, 0); step();
        checkOutput("t6_hold_clear", obs_cpu_hold, 0);
        checkOutput("t6_fetch_data", obs_if_rdata, 32'h13);
`endif

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 2) == 0, $urandom, $urandom);
`ifdef MEM_ARB_LOADER_EN
            setLoader($urandom_range(0, 9) == 0, $urandom, $urandom);
`endif
            step();
        end
        rst = 1'b0;
        setLoader(0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port word-addressed `memory` between the CPU instruction-fetch port and the CPU load/store port. Requests use a req/gnt handshake with one grant per cycle, and byte addresses are converted to word addresses. Read data is routed back to the owning port one cycle after grant. A starvation counter guarantees fetch progress under sustained load/store traffic. It sits between `cpu` and `memory`, replacing the `(load||store)` address mux inside the core.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive denied fetch cycles after which fetch wins priority.
- `CNT_W`, 3: width of the starvation counter; must hold `STARVE_LIMIT`.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr`  in  32  fetch byte address.
- `if_gnt`  out  1  fetch accepted this cycle (combinational).
- `if_rvalid`  out  1  fetch data valid (registered).
- `if_rdata`  out  32  fetch data.
- `ls_req`  in  1  load/store request; held with address, data and `ls_we` until `ls_gnt`.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_addr`  in  32  load/store byte address.
- `ls_wdata`  in  32  store data.
- `ls_gnt`  out  1  load/store accepted this cycle (combinational).
- `ls_rvalid`  out  1  load data valid (registered); never pulses for stores.
- `ls_rdata`  out  32  load data.
- `mem_address`  out  32  word address to memory (`byte_addr >> 2`).
- `mem_data_in`  out  32  write data to memory.
- `mem_write_enable`  out  1  memory write strobe.
- `mem_data_out`  in  32  memory read data; valid one cycle after address.

## Operation
- Arbitration is evaluated every cycle while `rst` = 0:
  - Only one requester active: that requester is granted.
  - Both active and `starve_cnt` < `STARVE_LIMIT`: ls wins.
  - Both active and `starve_cnt` >= `STARVE_LIMIT`: if wins.
- `starve_cnt` update:
  - Increments, saturating at `STARVE_LIMIT`, on each cycle with `if_req`=1 and `if_gnt`=0.
  - Clears on `if_gnt`=1 or `if_req`=0.
- Granted port drives `mem_address` = `addr[31:2]` zero-extended. `addr[1:0]` is ignored.
- Store grant: `mem_write_enable`=1 and `mem_data_in`=`ls_wdata` in the grant cycle.
- With no grant: `mem_write_enable`=0. `mem_address` holds the last granted address, so no spurious address toggling occurs.
- Read grant: a 2-bit registered tag {valid, owner} is set. The next cycle pulses the owner's `rvalid` for one cycle with `rdata` = `mem_data_out`. `rdata` registers hold their value afterwards.
- State machine on the tag: IDLE (no read in flight), RD_IF, RD_LS.
  - Any read grant enters RD_IF or RD_LS.
  - The next cycle returns data. It re-enters RD_* if another read is granted in the same cycle, otherwise returns to IDLE.
- A store grant does not enter RD_*.

## Timing
- Grant latency 0 cycles (combinational `gnt` from `req`). Read latency 1 cycle (grant at N, `rvalid` at N+1).
- Throughput: one access per cycle, back-to-back, alternating owners allowed. A data return and a new grant may occur in the same cycle.
- Reset values while `rst`=1 and the cycle after it:
  - `if_gnt`/`ls_gnt`=0, `if_rvalid`/`ls_rvalid`=0.
  - `if_rdata`/`ls_rdata`=0, `mem_write_enable`=0, `mem_address`=0, `mem_data_in`=0.
  - `starve_cnt`=0, state IDLE.
- Reset mid-read: an in-flight read is dropped and no `rvalid` pulses after `rst` deasserts.
- A requester that drops `req` before `gnt` is legal (request withdrawn). The arbiter keeps no memory of it.
- Simultaneous return and grant to the same port: `rvalid` for the old read at N+1, and for the new read at N+2.

## Configuration
- `MEM_ARB_LOADER_EN` defined: adds a third port for the boot loader, used to write program images.
  - Ports: `ld_req` in 1, `ld_addr` in 32, `ld_wdata` in 32, `ld_gnt` out 1, `cpu_hold` out 1.
  - Loader is write-only, has absolute priority, and is never starved-out.
  - `cpu_hold` = 1 from the first `ld_req` until the cycle after `ld_req` is last low. The core stalls on it.
  - `starve_cnt` does not increment while the loader is granted.
- Undefined: loader ports and logic are absent, and arbitration is the two-port scheme only.

## Test plan
- Fetch only: `if_req`=1, `if_addr`=0x10, mem word 4 = 0x00500093. Expect `if_gnt`=1 in the same cycle, `mem_address`=4, then `if_rvalid`=1 with `if_rdata`=0x00500093 the next cycle.
- Store then load: ls store to 0x20 of 0xDEADBEEF, then load from 0x20. Expect `mem_write_enable`=1 with `mem_address`=8 on the first grant, no `ls_rvalid` for it, then `ls_rvalid` with 0xDEADBEEF.
- Contention: `if_req` and `ls_req` both held high 10 cycles with `STARVE_LIMIT`=4. Expect ls granted cycles 0-3, if granted cycle 4, counter cleared, ls granted again cycle 5.
- Back-to-back alternating reads (if 0x0, ls 0x4, if 0x8). Expect one grant per cycle and `rvalid` pulses on the correct port in order, each one cycle late.
- Reset mid-read: grant a load at N, assert `rst` at N+1. Expect no `ls_rvalid`, all outputs 0, and a normal first grant after release.
- With `MEM_ARB_LOADER_EN`: `ld_req` writing 0x13 to 0x0 while `if_req`=1. Expect `ld_gnt`=1, `if_gnt`=0, `cpu_hold`=1 until one cycle after `ld_req` falls.
